nn_operand_seq: RTL and testbench

NN_OPERAND_SEQ -- requirements
Module: nn_operand_seq

---
 rtl/nn_operand_seq.sv | 145 ++++++++++++++
 tb/tb_nn_operand_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/nn_operand_seq.sv
// Operand sequencer for a bit-serial NN MAC: fetches activation/weight pairs and
// streams each activation LSB-first against a held weight. Optional ALU backpressure via SEQ_STALL_EN.
module nn_operand_seq #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] vec_len,
    input  logic [ADDR_W-1:0] base_in,
    input  logic [ADDR_W-1:0] base_wt,
`ifdef SEQ_STALL_EN
    input  logic              alu_ready,
`endif
    output logic              busy,
    output logic              done,
    output logic              in_re,
    output logic              wt_re,
    output logic [ADDR_W-1:0] in_addr,
    output logic [ADDR_W-1:0] wt_addr,
    input  logic [DATA_W-1:0] in_rdata,
    input  logic [DATA_W-1:0] wt_rdata,
    output logic              alu_in_a_lsb,
    output logic [DATA_W-1:0] alu_in_b,
    output logic              alu_op,
    output logic              alu_first,
    output logic              alu_last
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] len_q, bin_q, bwt_q, k_q;
    logic [CNT_W-1:0]  bit_q;
    logic [DATA_W-1:0] sreg, b_q;
    logic              step_en, last_bit, last_pair;

`ifdef SEQ_STALL_EN
    assign step_en = alu_ready;
`else
    assign step_en = 1'b1;
`endif

    assign last_bit  = (bit_q == CNT_W'(DATA_W - 1));
    // Extra MSB keeps k+1 from wrapping when vec_len is the largest encodable count.
    assign last_pair = (({1'b0, k_q} + (ADDR_W + 1)'(1)) >= {1'b0, len_q});

    assign alu_in_a_lsb = sreg[0];
    assign alu_in_b     = b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        busy      = (state != S_IDLE);
        done      = 1'b0;
        in_re     = 1'b0;
        wt_re     = 1'b0;
        in_addr   = '0;
        wt_addr   = '0;
        alu_op    = 1'b0;
        alu_first = 1'b0;
        alu_last  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = (vec_len == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                in_re    = 1'b1;
                wt_re    = 1'b1;
                in_addr  = bin_q + k_q;
                wt_addr  = bwt_q + k_q;
                state_nx = S_LOAD;
            end
            S_LOAD: state_nx = S_SHIFT;
            S_SHIFT: begin
                if (step_en) begin
                    alu_op    = 1'b1;
                    alu_first = (k_q == '0) && (bit_q == '0);
                    alu_last  = last_pair && last_bit;
                    if (last_bit) state_nx = last_pair ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q <= '0;
            bin_q <= '0;
            bwt_q <= '0;
            k_q   <= '0;
            bit_q <= '0;
            sreg  <= '0;
            b_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_q <= vec_len;
                        bin_q <= base_in;
                        bwt_q <= base_wt;
                        k_q   <= '0;
                        bit_q <= '0;
                    end
                end
                S_LOAD: begin
                    sreg  <= in_rdata;
                    b_q   <= wt_rdata;
                    bit_q <= '0;
                end
                S_SHIFT: begin
                    if (step_en) begin
                        sreg <= sreg >> 1;
                        if (last_bit) begin
                            bit_q <= '0;
                            k_q   <= k_q + ADDR_W'(1);
                        end else begin
                            bit_q <= bit_q + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_operand_seq.sv
// Self-checking bench for nn_operand_seq: directed table, random runs against a
// per-cycle trace model, and a mid-run reset sequence.
module tb_nn_operand_seq;

    localparam int DW = 8;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] vec_len = '0, base_in = '0, base_wt = '0;
    logic          busy, done, in_re, wt_re;
    logic [AW-1:0] in_addr, wt_addr;
    logic [DW-1:0] in_rdata = '0, wt_rdata = '0;
    logic          alu_in_a_lsb;
    logic [DW-1:0] alu_in_b;
    logic          alu_op, alu_first, alu_last;
`ifdef SEQ_STALL_EN
    logic          alu_ready = 1'b1;
`endif

    logic [DW-1:0] in_mem [64];
    logic [DW-1:0] wt_mem [64];

    int checks = 0;
    int failures = 0;

    nn_operand_seq #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .vec_len(vec_len), .base_in(base_in), .base_wt(base_wt),
`ifdef SEQ_STALL_EN
        .alu_ready(alu_ready),
`endif
        .busy(busy), .done(done), .in_re(in_re), .wt_re(wt_re),
        .in_addr(in_addr), .wt_addr(wt_addr),
        .in_rdata(in_rdata), .wt_rdata(wt_rdata),
        .alu_in_a_lsb(alu_in_a_lsb), .alu_in_b(alu_in_b),
        .alu_op(alu_op), .alu_first(alu_first), .alu_last(alu_last)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories: data valid the cycle after the enable.
    always @(posedge clk) begin
        if (in_re) in_rdata <= in_mem[in_addr];
        if (wt_re) wt_rdata <= wt_mem[wt_addr];
    end

    typedef struct packed {
        bit          busy, done, re_i, re_w;
        bit [AW-1:0] ai, aw;
        bit          op, lsb;
        bit [DW-1:0] b;
        bit          first, last;
    } obs_t;

    typedef struct {
        int       len, bi, bw;
        bit       repulse;
        int       exp_done;
        bit       chk_lsb;
        bit [23:0] exp_lsb;
        bit       chk_addr;
        bit [23:0] exp_addr;
    } vec_t;

    function automatic obs_t get_obs(bit show);
        obs_t o;
        o.busy  = busy;
        o.done  = done;
        o.re_i  = in_re;
        o.re_w  = wt_re;
        o.ai    = in_re ? in_addr : '0;
        o.aw    = wt_re ? wt_addr : '0;
        o.op    = alu_op;
        o.lsb   = show ? alu_in_a_lsb : 1'b0;
        o.b     = show ? alu_in_b : '0;
        o.first = alu_first;
        o.last  = alu_last;
        return o;
    endfunction

    task automatic check(string name, int c, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, c, got, exp);
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 64; i++) begin
            in_mem[i] = DW'($urandom);
            wt_mem[i] = DW'($urandom);
        end
    endtask

    // Called just after a negedge; the following posedge is E0.
    task automatic run_case(input int len, input int bi, input int bw, input bit repulse,
                            input int stall_at, output int done_cyc, output int n_done,
                            output bit [23:0] lsb_s, output bit [23:0] addr_s);
        obs_t exp_q[$];
        obs_t e, g;
        int   idx, total;
        bit   stalled;
        exp_q.delete();
        if (len == 0) begin
            e = '0; e.busy = 1; e.done = 1; exp_q.push_back(e);
        end else begin
            for (int k = 0; k < len; k++) begin
                int ai, aw;
                ai = (bi + k) % 64;
                aw = (bw + k) % 64;
                e = '0; e.busy = 1; e.re_i = 1; e.re_w = 1; e.ai = AW'(ai); e.aw = AW'(aw);
                exp_q.push_back(e);
                e = '0; e.busy = 1; exp_q.push_back(e);
                for (int i = 0; i < DW; i++) begin
                    e = '0; e.busy = 1; e.op = 1;
                    e.lsb   = in_mem[ai][i];
                    e.b     = wt_mem[aw];
                    e.first = (k == 0 && i == 0);
                    e.last  = (k == len - 1 && i == DW - 1);
                    exp_q.push_back(e);
                end
            end
            e = '0; e.busy = 1; e.done = 1; exp_q.push_back(e);
        end
        e = '0; exp_q.push_back(e); exp_q.push_back(e);

        vec_len = AW'(len); base_in = AW'(bi); base_wt = AW'(bw); start = 1'b1;
        done_cyc = -1; n_done = 0; lsb_s = '0; addr_s = '0; idx = 0;
        total = exp_q.size() + ((stall_at != 0) ? 3 : 0);
        for (int c = 1; c <= total; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                vec_len = AW'($urandom); base_in = AW'($urandom); base_wt = AW'($urandom);
            end
            if (repulse && c == 5) start = 1'b1;
            if (repulse && c == 6) start = 1'b0;
            stalled = (stall_at != 0) && (c >= stall_at) && (c < stall_at + 3);
`ifdef SEQ_STALL_EN
            alu_ready = !stalled;
`endif
            #1;
            g = get_obs(alu_op || stalled);
            e = exp_q[idx];
            if (stalled) begin e.op = 0; e.first = 0; e.last = 0; end
            check("trace", c, 64'(g), 64'(e));
            if (done) begin n_done++; if (done_cyc < 0) done_cyc = c; end
            if (alu_op) lsb_s = {lsb_s[22:0], alu_in_a_lsb};
            if (in_re) addr_s = {addr_s[17:0], in_addr};
            if (!stalled) idx++;
        end
`ifdef SEQ_STALL_EN
        alu_ready = 1'b1;
`endif
    endtask

    vec_t      vt[4];
    int        dc, nd, len;
    bit [23:0] ls, as;

    initial begin
        vt[0] = '{3, 0, 16, 0, 31, 1, 24'b10100101_10000000_11111111, 0, 24'h0};
        vt[1] = '{0, 5, 9, 0, 1, 0, 24'h0, 0, 24'h0};
        vt[2] = '{4, 62, 7, 0, 41, 0, 24'h0, 1, {6'd62, 6'd63, 6'd0, 6'd1}};
        vt[3] = '{2, 10, 20, 1, 21, 0, 24'h0, 0, 24'h0};

        fill_mem();
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", 0, 64'(get_obs(1'b1)), 64'h0);
        rst = 1'b0;

        for (int t = 0; t < 4; t++) begin
            fill_mem();
            if (t == 0) begin
                in_mem[0] = 8'hA5; in_mem[1] = 8'h01; in_mem[2] = 8'hFF;
            end
            run_case(vt[t].len, vt[t].bi, vt[t].bw, vt[t].repulse, 0, dc, nd, ls, as);
            check("done_cycle", t, 64'(dc), 64'(vt[t].exp_done));
            check("done_count", t, 64'(nd), 64'd1);
            if (vt[t].chk_lsb)  check("lsb_stream", t, 64'(ls), 64'(vt[t].exp_lsb));
            if (vt[t].chk_addr) check("addr_stream", t, 64'(as), 64'(vt[t].exp_addr));
        end

        for (int r = 0; r < 20; r++) begin
            fill_mem();
            len = int'($urandom_range(0, 5));
            run_case(len, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                     bit'($urandom_range(0, 1)), 0, dc, nd, ls, as);
            check("rand_done_cycle", r, 64'(dc), 64'((len == 0) ? 1 : len * (DW + 2) + 1));
            check("rand_done_count", r, 64'(nd), 64'd1);
        end

        // Reset during SHIFT of pair 1, then restart straight out of reset.
        vec_len = 6'd3; base_in = 6'd0; base_wt = 6'd8; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 2; c <= 15; c++) @(negedge clk);
        #1;
        check("midrun_in_shift", 15, 64'(alu_op), 64'd1);
        rst = 1'b1;
        #1;
        check("midrun_reset_outputs", 15, 64'(get_obs(1'b1)), 64'h0);
        for (int c = 16; c <= 17; c++) begin
            @(negedge clk); #1;
            check("reset_held_outputs", c, 64'(get_obs(1'b1)), 64'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        fill_mem();
        run_case(2, 3, 40, 0, 0, dc, nd, ls, as);
        check("post_reset_done_cycle", 0, 64'(dc), 64'd21);
        check("post_reset_done_count", 0, 64'(nd), 64'd1);

`ifdef SEQ_STALL_EN
        fill_mem();
        run_case(2, 12, 30, 0, 6, dc, nd, ls, as);
        check("stall_done_cycle", 0, 64'(dc), 64'd24);
        check("stall_done_count", 0, 64'(nd), 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
